magnitude_moving_avg: RTL and testbench

Sliding-window moving average placed directly downstream of `magnitude`. It consumes `magnitude`'s `data_out` / `data_out_ready` stream and emits one smoothed sample per accepted input. The smoothed value is the mean of the last 2^LOG2_WINDOW magnitudes. It feeds the level-metering and display logic that follows it.

---
 rtl/magnitude_moving_avg.sv | 107 ++++++++++
 tb/tb_magnitude_moving_avg.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_moving_avg.sv
// Sliding-window mean of the magnitude stream: a zero-preloaded delay line plus
// a running sum that adds each new sample and subtracts the one it overwrites.
//
// state | meaning
// CLEAR | zero the delay line one entry per cycle, busy=1, inputs dropped
// RUN   | accept strobed samples, update running sum, emit window mean
module magnitude_moving_avg #(
    parameter int DATA_IN_BITS  = 17,
    parameter int LOG2_WINDOW   = 4,
    parameter int DATA_OUT_BITS = DATA_IN_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_in_ready,
    input  logic [DATA_IN_BITS-1:0]  data_in,
    output logic                     data_out_ready,
    output logic [DATA_OUT_BITS-1:0] data_out,
    output logic                     busy
);

    localparam int DEPTH = 1 << LOG2_WINDOW;
    localparam int SUM_W = DATA_IN_BITS + LOG2_WINDOW;

    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [LOG2_WINDOW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]         sum_q, sum_d, sum_next;
    logic [DATA_OUT_BITS-1:0] data_out_q, data_out_d;
    logic                     data_out_ready_q, data_out_ready_d;

    logic [DATA_IN_BITS-1:0]  mem [DEPTH];
    logic                     mem_we;
    logic [DATA_IN_BITS-1:0]  mem_wdata;
    logic [DATA_IN_BITS-1:0]  old_sample;
    logic                     accept;

    assign old_sample = mem[wr_ptr_q];
    assign accept     = (state_q == ST_RUN) && data_in_ready;
    // sum always covers old_sample, so the subtraction cannot go negative
    assign sum_next   = sum_q + SUM_W'(data_in) - SUM_W'(old_sample);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_CLEAR;
            wr_ptr_q         <= '0;
            sum_q            <= '0;
            data_out_q       <= '0;
            data_out_ready_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            sum_q            <= sum_d;
            data_out_q       <= data_out_d;
            data_out_ready_q <= data_out_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == ST_CLEAR) && (wr_ptr_q == LOG2_WINDOW'(DEPTH - 1))) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        sum_d            = sum_q;
        data_out_d       = data_out_q;
        data_out_ready_d = 1'b0;
        mem_we           = 1'b0;
        mem_wdata        = data_in;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                wr_ptr_d  = wr_ptr_q + LOG2_WINDOW'(1);
                sum_d     = '0;
            end
            ST_RUN: begin
                if (accept) begin
                    mem_we           = 1'b1;
                    wr_ptr_d         = wr_ptr_q + LOG2_WINDOW'(1);
                    sum_d            = sum_next;
                    data_out_d       = DATA_OUT_BITS'(sum_next[SUM_W-1:LOG2_WINDOW]);
                    data_out_ready_d = 1'b1;
                end
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
            end
        endcase
    end

    always_comb begin
        busy           = (state_q == ST_CLEAR);
        data_out       = data_out_q;
        data_out_ready = data_out_ready_q;
    end

endmodule

// File: tb/tb_magnitude_moving_avg.sv
// Directed bench for magnitude_moving_avg: window-4 scenarios plus a window-16 instance.
module tb_magnitude_moving_avg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d_rdy = 1'b0;
    logic [16:0] d_in = '0;
    logic        o_rdy;
    logic [16:0] o_dat;
    logic        busy;
    logic        e_rdy = 1'b0;
    logic [16:0] e_in = '0;
    logic        e_ordy;
    logic [16:0] e_odat;
    logic        e_busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    magnitude_moving_avg #(.DATA_IN_BITS(17), .LOG2_WINDOW(2)) dut (
        .clk(clk), .rst(rst), .data_in_ready(d_rdy), .data_in(d_in),
        .data_out_ready(o_rdy), .data_out(o_dat), .busy(busy)
    );

    magnitude_moving_avg dut16 (
        .clk(clk), .rst(rst), .data_in_ready(e_rdy), .data_in(e_in),
        .data_out_ready(e_ordy), .data_out(e_odat), .busy(e_busy)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            $display("FAIL clear_timeout: busy still %0b after %0d cycles, expected 0", busy, n);
            errors++;
        end
        checks++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (o_dat !== 17'd0) begin $display("FAIL rst_data: got %0d expected 0", o_dat); errors++; end
        checks++;
        if (o_rdy !== 1'b0) begin $display("FAIL rst_ready: got %0b expected 0", o_rdy); errors++; end
        checks++;
        if (busy !== 1'b1) begin $display("FAIL rst_busy: got %0b expected 1", busy); errors++; end
        checks++;
        repeat (3) @(negedge clk);
        if (busy !== 1'b1) begin $display("FAIL rst_busy_held: got %0b expected 1", busy); errors++; end
        checks++;
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (busy !== (i < 4)) begin
                $display("FAIL clear_busy[edge %0d]: got %0b expected %0b", i, busy, (i < 4));
                errors++;
            end
            checks++;
        end
        if (e_busy !== 1'b1) begin $display("FAIL w16_busy_early: got %0b expected 1", e_busy); errors++; end
        checks++;
    endtask

    task automatic test_ramp();
        int vals [5] = '{4, 8, 12, 16, 20};
        int exps [5] = '{1, 3, 6, 10, 14};
        for (int i = 0; i < 5; i++) begin
            d_rdy = 1'b1;
            d_in  = 17'(vals[i]);
            @(negedge clk);
            if (o_rdy !== 1'b1) begin $display("FAIL ramp_ready[%0d]: got %0b expected 1", i, o_rdy); errors++; end
            checks++;
            if (o_dat !== 17'(exps[i])) begin
                $display("FAIL ramp_data[%0d]: got %0d expected %0d", i, o_dat, exps[i]);
                errors++;
            end
            checks++;
        end
        d_rdy = 1'b0;
        @(negedge clk);
        if (o_rdy !== 1'b0) begin $display("FAIL ramp_pulse_end: got %0b expected 0", o_rdy); errors++; end
        checks++;
    endtask

    task automatic test_saturation();
        int exps [8] = '{32767, 65535, 98303, 131071, 131071, 131071, 131071, 131071};
        do_reset();
        wait_clear();
        for (int i = 0; i < 8; i++) begin
            d_rdy = 1'b1;
            d_in  = 17'd131071;
            @(negedge clk);
            if (o_rdy !== 1'b1) begin $display("FAIL sat_ready[%0d]: got %0b expected 1", i, o_rdy); errors++; end
            checks++;
            if (o_dat !== 17'(exps[i])) begin
                $display("FAIL sat_data[%0d]: got %0d expected %0d", i, o_dat, exps[i]);
                errors++;
            end
            checks++;
        end
        d_rdy = 1'b0;
    endtask

    task automatic test_gapped();
        do_reset();
        d_rdy = 1'b1;
        d_in  = 17'd100;
        @(negedge clk);
        d_rdy = 1'b0;
        if (o_rdy !== 1'b0) begin $display("FAIL busy_drop_ready: got %0b expected 0", o_rdy); errors++; end
        checks++;
        wait_clear();
        d_rdy = 1'b1;
        @(negedge clk);
        d_rdy = 1'b0;
        if (o_rdy !== 1'b1 || o_dat !== 17'd25) begin
            $display("FAIL gap_first: got ready=%0b data=%0d expected ready=1 data=25", o_rdy, o_dat);
            errors++;
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (o_rdy !== 1'b0 || o_dat !== 17'd25) begin
                $display("FAIL gap_idle[%0d]: got ready=%0b data=%0d expected ready=0 data=25", i, o_rdy, o_dat);
                errors++;
            end
            checks++;
        end
        d_rdy = 1'b1;
        @(negedge clk);
        d_rdy = 1'b0;
        if (o_rdy !== 1'b1 || o_dat !== 17'd50) begin
            $display("FAIL gap_second: got ready=%0b data=%0d expected ready=1 data=50", o_rdy, o_dat);
            errors++;
        end
        checks++;
    endtask

    task automatic test_mid_reset();
        int exps [6] = '{10, 20, 30, 40, 40, 40};
        int n = 0;
        do_reset();
        wait_clear();
        for (int i = 0; i < 6; i++) begin
            d_rdy = 1'b1;
            d_in  = 17'd40;
            @(negedge clk);
            if (o_rdy !== 1'b1 || o_dat !== 17'(exps[i])) begin
                $display("FAIL mid_fill[%0d]: got ready=%0b data=%0d expected ready=1 data=%0d", i, o_rdy, o_dat, exps[i]);
                errors++;
            end
            checks++;
        end
        d_rdy = 1'b0;
        #2 rst = 1'b0;
        #1;
        if (o_rdy !== 1'b0) begin $display("FAIL mid_rst_ready: got %0b expected 0", o_rdy); errors++; end
        checks++;
        if (o_dat !== 17'd0) begin $display("FAIL mid_rst_data: got %0d expected 0", o_dat); errors++; end
        checks++;
        if (busy !== 1'b1) begin $display("FAIL mid_rst_busy: got %0b expected 1", busy); errors++; end
        checks++;
        @(posedge clk);
        #2 rst = 1'b1;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n !== 4) begin $display("FAIL mid_clear_len: got %0d edges expected 4", n); errors++; end
        checks++;
        @(negedge clk);
        d_rdy = 1'b1;
        d_in  = 17'd8;
        @(negedge clk);
        d_rdy = 1'b0;
        if (o_rdy !== 1'b1 || o_dat !== 17'd2) begin
            $display("FAIL mid_after: got ready=%0b data=%0d expected ready=1 data=2", o_rdy, o_dat);
            errors++;
        end
        checks++;
    endtask

    task automatic test_window16();
        int hist [16];
        int sum = 0;
        int ptr = 0;
        int n = 0;
        int v;
        for (int i = 0; i < 16; i++) hist[i] = 0;
        do_reset();
        while (e_busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n !== 16) begin $display("FAIL w16_clear_len: got %0d edges expected 16", n); errors++; end
        checks++;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            v = (i % 5 == 3) ? 131071 : ((i * 7919 + 13) % 131072);
            sum = sum + v - hist[ptr];
            hist[ptr] = v;
            ptr = (ptr + 1) % 16;
            e_rdy = 1'b1;
            e_in  = 17'(v);
            @(negedge clk);
            if (e_ordy !== 1'b1 || e_odat !== 17'(sum / 16)) begin
                $display("FAIL w16_data[%0d]: got ready=%0b data=%0d expected ready=1 data=%0d", i, e_ordy, e_odat, sum / 16);
                errors++;
            end
            checks++;
        end
        e_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_gapped();
        test_mid_reset();
        test_window16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
